rx_event_tracker: RTL and testbench
===================================

# rx_event_tracker

Parametrised successor to the ADC receive-event manager. It counts per-channel end-of-write pulses and derives the fully received event count, defined as the minimum over enabled channels. From that count it raises read requests toward the tx manager and one-cycle check strobes toward the L1A checker. It also identifies the most-lagging ADC channel, flags excessive inter-channel skew, and is wrap-safe at the counter width.

## Interface
Parameters:
- N_CH, 16, number of ADC channels (2..32)
- CNT_W, 16, event counter width; all counts are modulo 2^CNT_W
- LAG_LIMIT, 4, maximum allowed leader-minus-laggard spread before lag_err sets
- IDX_W, 5, width of channel index outputs (≥ clog2(N_CH))

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- din  in  N_CH  per-channel one-cycle pulse, one received event per pulse
- ch_mask  in  N_CH  1 = channel enabled; masked channels are excluded from min, lag and error logic
- evt_tx  in  CNT_W  events already read out (from tx manager)
- clr_err  in  1  clears sticky lag_err
- need_read  out  1  event_receive ahead of evt_tx
- need_check  out  1  one-cycle strobe, event_receive advanced by 1
- event_receive  out  CNT_W  fully received event count
- lag_ch  out  IDX_W  index of the most-lagging enabled channel
- lag_depth  out  CNT_W  max_ahead - min_ahead over enabled channels
- lag_err  out  1  sticky, lag_depth exceeded LAG_LIMIT

## Operation
- Stage 1, counters: cnt[i] <= cnt[i] + din[i], wrapping at 2^CNT_W. It counts regardless of ch_mask, so unmasking a channel needs no resync.
- Stage 2, statistics, registered from stage-1 values:
  - ahead[i] = (cnt[i] - evt_tx) mod 2^CNT_W, unsigned.
  - Channels never trail evt_tx by construction, so the modular difference is wrap-safe.
- min_ahead / max_ahead: taken over enabled channels only.
- event_receive = evt_tx + min_ahead, mod 2^CNT_W.
- need_read = (min_ahead != 0).
- need_check = 1 when new event_receive == previous event_receive + 1 (mod). Counters move at most 1 per cycle, so larger jumps occur only via evt_tx/mask changes; these do not strobe.
- lag_ch = lowest index i among enabled channels with ahead[i] == min_ahead.
- lag_depth = max_ahead - min_ahead.
- lag_err:
  - Sets when lag_depth > LAG_LIMIT.
  - Holds until clr_err.
  - If set and clear coincide, set wins.
- ch_mask == 0 (no channel enabled):
  - min_ahead = max_ahead = 0, so event_receive = evt_tx.
  - need_read = 0, lag_ch = 0, lag_depth = 0.
  - lag_err holds its value.
- Changing ch_mask or evt_tx mid-run takes effect on the next stage-2 update. need_check does not pulse for the resulting step.
- The stage-2 comparator tree may be pipelined internally only if total latency stays as stated under Timing.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - all cnt = 0
  - event_receive = 0, need_read = 0, need_check = 0
  - lag_ch = 0, lag_depth = 0, lag_err = 0
  - the previous-value register = 0
- Latency:
  - A din pulse sampled at edge k is in cnt at edge k.
  - Derived outputs reflect it at edge k+1, i.e. 2 cycles from the din assertion cycle to the output change.
- evt_tx and ch_mask sampled at edge k affect outputs at edge k+1.
- need_check is exactly one cycle wide per increment. Back-to-back increments produce consecutive strobes.
- Wrap-around: a cnt transition from 2^CNT_W-1 to 0 is a normal +1. event_receive wraps likewise, and need_check pulses.
- Reset asserted mid-operation clears everything immediately. The first post-reset din pulse is counted from 0.

## Test plan
- Reset, then one din pulse on all 16 channels with evt_tx=0 -> event_receive=1, need_read=1, need_check one cycle, lag_depth=0, lag_ch=0.
- Pulse only channels 0..14 three times -> event_receive=0, need_read=0, lag_ch=15, lag_depth=3, lag_err=0. Then pulse ch15 once -> need_check strobe, event_receive=1.
- Pulse ch0..14 five times and ch15 none (LAG_LIMIT=4) -> lag_depth=5, lag_err=1. lag_err stays set after ch15 catches up; clr_err clears it. clr_err coincident with a new violation -> stays 1.
- Mask ch15 in the previous scenario -> event_receive jumps to 5 with no need_check strobe, and lag_ch is no longer 15. ch_mask=0 -> event_receive=evt_tx, need_read=0.
- Preload via 65535 pulses on all channels with evt_tx=65534, then one more pulse -> event_receive=0, need_check=1, need_read=1 (ahead=2).
- Assert reset_n=0 mid-burst for one cycle -> all outputs 0 without waiting for a clock edge; the following pulse gives event_receive=1.

Source files
------------

// File: rtl/rx_event_tracker.sv
// rx_event_tracker: per-channel receive counters plus a registered statistics
// stage that derives the fully received event count, read/check requests,
// the most-lagging enabled channel and a sticky inter-channel skew error.

// One channel: wrapping event counter and its lead over the read-out count.
module rx_evt_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic [CNT_W-1:0] evt_ref,
  output logic [CNT_W-1:0] ahead
);
  logic [CNT_W-1:0] cnt;

  // Count every pulse regardless of masking so re-enabling needs no resync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + CNT_W'(din);
  end

  // Modular difference stays correct across wrap since cnt never trails evt_ref.
  assign ahead = cnt - evt_ref;
endmodule

module rx_event_tracker #(
  parameter int N_CH      = 16,
  parameter int CNT_W     = 16,
  parameter int LAG_LIMIT = 4,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  din,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [CNT_W-1:0] evt_tx,
  input  logic             clr_err,
  output logic             need_read,
  output logic             need_check,
  output logic [CNT_W-1:0] event_receive,
  output logic [IDX_W-1:0] lag_ch,
  output logic [CNT_W-1:0] lag_depth,
  output logic             lag_err
);
  // Side inputs are staged alongside the counters so everything sampled at
  // one edge lands on the outputs together one edge later.
  logic [N_CH-1:0]             mask_q, mask_s2;
  logic [CNT_W-1:0]            evt_q, evt_s2;
  logic                        clr_q;
  logic [N_CH-1:0][CNT_W-1:0]  ahead;

  logic [CNT_W-1:0] min_a, max_a, er_n, depth_n;
  logic [IDX_W-1:0] min_idx;
  logic             any_en;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      rx_evt_lane #(.CNT_W(CNT_W)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din[g]),
        .evt_ref (evt_q),
        .ahead   (ahead[g])
      );
    end
  endgenerate

  // Stage-1 capture of mask, read-out count and error clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      evt_q  <= '0;
      clr_q  <= 1'b0;
    end else begin
      mask_q <= ch_mask;
      evt_q  <= evt_tx;
      clr_q  <= clr_err;
    end
  end

  // Min/max over enabled channels; strict compare keeps the lowest index on ties.
  always_comb begin
    min_a   = '0;
    max_a   = '0;
    min_idx = '0;
    any_en  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (mask_q[i]) begin
        if (!any_en || ahead[i] < min_a) begin
          min_a   = ahead[i];
          min_idx = IDX_W'(i);
        end
        if (!any_en || ahead[i] > max_a) max_a = ahead[i];
        any_en = 1'b1;
      end
    end
    er_n    = evt_q + min_a;
    depth_n = max_a - min_a;
  end

  // Stage-2 outputs. A +1 step caused by a mask or read-out change is not a
  // newly received event, so the check strobe is suppressed for it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_receive <= '0;
      need_read     <= 1'b0;
      need_check    <= 1'b0;
      lag_ch        <= '0;
      lag_depth     <= '0;
      lag_err       <= 1'b0;
      mask_s2       <= '0;
      evt_s2        <= '0;
    end else begin
      event_receive <= er_n;
      need_read     <= (min_a != '0);
      need_check    <= (er_n == event_receive + CNT_W'(1)) &&
                       (evt_q == evt_s2) && (mask_q == mask_s2);
      lag_ch        <= min_idx;
      lag_depth     <= depth_n;
      lag_err       <= (depth_n > CNT_W'(LAG_LIMIT)) | (lag_err & ~clr_q);
      mask_s2       <= mask_q;
      evt_s2        <= evt_q;
    end
  end
endmodule

// File: tb/tb_rx_event_tracker.sv
// Directed bench for rx_event_tracker: a vector table for the steady-state
// behaviour plus hand-written wrap, back-to-back strobe and reset sequences.
module tb_rx_event_tracker;
  localparam int N_CH = 16, CNT_W = 16, LAG_LIMIT = 4, IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N_CH-1:0]  din, ch_mask;
  logic [CNT_W-1:0] evt_tx;
  logic             clr_err;
  logic             need_read, need_check, lag_err;
  logic [CNT_W-1:0] event_receive, lag_depth;
  logic [IDX_W-1:0] lag_ch;

  int n_chk = 0, n_fail = 0;

  rx_event_tracker #(.N_CH(N_CH), .CNT_W(CNT_W), .LAG_LIMIT(LAG_LIMIT), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .ch_mask(ch_mask), .evt_tx(evt_tx),
    .clr_err(clr_err), .need_read(need_read), .need_check(need_check),
    .event_receive(event_receive), .lag_ch(lag_ch), .lag_depth(lag_depth), .lag_err(lag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din, mask, evt;
    logic        clr;
    logic [15:0] er;
    logic        nr, nc;
    logic [4:0]  lch;
    logic [15:0] dep;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] d, m, e, input logic c,
                     input logic [15:0] er, input logic nr, nc,
                     input logic [4:0] lch, input logic [15:0] dep, input logic err);
    vec_t v;
    v.din = d; v.mask = m; v.evt = e; v.clr = c;
    v.er = er; v.nr = nr; v.nc = nc; v.lch = lch; v.dep = dep; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] er, input logic nr, nc,
                         input logic [4:0] lch, input logic [15:0] dep, input logic err);
    chk({tag, ".event_receive"}, 32'(event_receive), 32'(er));
    chk({tag, ".need_read"},     32'(need_read),     32'(nr));
    chk({tag, ".need_check"},    32'(need_check),    32'(nc));
    chk({tag, ".lag_ch"},        32'(lag_ch),        32'(lch));
    chk({tag, ".lag_depth"},     32'(lag_depth),     32'(dep));
    chk({tag, ".lag_err"},       32'(lag_err),       32'(err));
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b1; din = '0; ch_mask = 16'hffff; evt_tx = '0; clr_err = 1'b0;
    #3 reset_n = 1'b0;
    #1 chk_all("reset", 16'd0, 0, 0, 5'd0, 16'd0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    //   din       mask      evt  clr   er  nr nc lch dep err
    add(16'hffff, 16'hffff, 16'd0, 0, 16'd1, 1, 1, 5'd0,  16'd0, 0);
    add(16'h0000, 16'hffff, 16'd1, 0, 16'd1, 0, 0, 5'd0,  16'd0, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd1, 0, 0, 5'd15, 16'd1, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd1, 0, 0, 5'd15, 16'd2, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd1, 0, 0, 5'd15, 16'd3, 0);
    add(16'h8000, 16'hffff, 16'd1, 0, 16'd2, 1, 1, 5'd15, 16'd2, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd2, 1, 0, 5'd15, 16'd3, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd2, 1, 0, 5'd15, 16'd4, 0);
    add(16'h7fff, 16'hffff, 16'd1, 0, 16'd2, 1, 0, 5'd15, 16'd5, 1);
    add(16'h8000, 16'hffff, 16'd1, 0, 16'd3, 1, 1, 5'd15, 16'd4, 1);
    add(16'h8000, 16'hffff, 16'd1, 0, 16'd4, 1, 1, 5'd15, 16'd3, 1);
    add(16'h0000, 16'hffff, 16'd1, 1, 16'd4, 1, 0, 5'd15, 16'd3, 0);
    add(16'h7fff, 16'hffff, 16'd1, 1, 16'd4, 1, 0, 5'd15, 16'd4, 0);
    add(16'h7fff, 16'hffff, 16'd1, 1, 16'd4, 1, 0, 5'd15, 16'd5, 1);
    add(16'h7fff, 16'hffff, 16'd1, 1, 16'd4, 1, 0, 5'd15, 16'd6, 1);
    add(16'h0000, 16'h7fff, 16'd1, 0, 16'd10, 1, 0, 5'd0, 16'd0, 1);
    add(16'h8000, 16'hffff, 16'd1, 0, 16'd5, 1, 0, 5'd15, 16'd5, 1);
    add(16'h0000, 16'h0000, 16'd1, 0, 16'd1, 0, 0, 5'd0,  16'd0, 1);
    add(16'h0000, 16'h0000, 16'd2, 0, 16'd2, 0, 0, 5'd0,  16'd0, 1);
    add(16'h0000, 16'h0000, 16'd2, 1, 16'd2, 0, 0, 5'd0,  16'd0, 0);
    add(16'h0000, 16'hffff, 16'd5, 0, 16'd5, 0, 0, 5'd15, 16'd5, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      din = tbl[i].din; ch_mask = tbl[i].mask; evt_tx = tbl[i].evt; clr_err = tbl[i].clr;
      @(posedge clk); #1;
      din = '0; clr_err = 1'b0;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].er, tbl[i].nr, tbl[i].nc,
              tbl[i].lch, tbl[i].dep, tbl[i].err);
    end

    // Wrap: 65536 pulses on all channels against evt_tx = 65534.
    ch_mask = 16'hffff; evt_tx = 16'd65534;
    do_reset();
    @(negedge clk); din = 16'hffff;
    repeat (65535) @(posedge clk);
    #1 chk("wrap_pre.event_receive", 32'(event_receive), 32'd65534);
    chk("wrap_pre.need_check", 32'(need_check), 32'd1);
    @(posedge clk); #1 din = '0;
    chk("wrap_last.event_receive", 32'(event_receive), 32'd65535);
    chk("wrap_last.need_check", 32'(need_check), 32'd1);
    @(posedge clk); #1;
    chk_all("wrap", 16'd0, 1, 1, 5'd0, 16'd0, 0);
    @(posedge clk); #1;
    chk("wrap_after.need_check", 32'(need_check), 32'd0);
    chk("wrap_after.event_receive", 32'(event_receive), 32'd0);

    // Latency, back-to-back strobes, then asynchronous reset mid-burst.
    @(negedge clk); evt_tx = '0;
    repeat (2) @(negedge clk);
    din = 16'hffff;
    @(posedge clk); #1 chk("lat_hold.event_receive", 32'(event_receive), 32'd0);
    @(posedge clk); #1 chk("b2b1.event_receive", 32'(event_receive), 32'd1);
    chk("b2b1.need_check", 32'(need_check), 32'd1);
    @(posedge clk); #1 chk("b2b2.event_receive", 32'(event_receive), 32'd2);
    chk("b2b2.need_check", 32'(need_check), 32'd1);
    chk("b2b2.need_read", 32'(need_read), 32'd1);
    @(negedge clk); reset_n = 1'b0;
    #1 chk_all("async_rst", 16'd0, 0, 0, 5'd0, 16'd0, 0);
    @(negedge clk); reset_n = 1'b1; din = '0;
    repeat (2) @(negedge clk);
    din = 16'hffff;
    @(posedge clk); #1 din = '0;
    @(posedge clk); #1;
    chk_all("post_rst", 16'd1, 1, 1, 5'd0, 16'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
